mac_feed_ctrl: RTL

MAC_FEED_CTRL -- requirements
Module: mac_feed_ctrl

---
 rtl/mac_feed_ctrl_pkg.sv | 20 ++
 rtl/mac_feed_ctrl_feed_buffer.sv | 44 ++++
 rtl/mac_feed_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mac_feed_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_feed_ctrl_pkg
// Description : Shared types and default cell widths for the MAC feed
//               controller and its local operand buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_feed_ctrl_pkg;

   localparam int c_IF_CELL_SIZE     = 8;
   localparam int c_FILTER_CELL_SIZE = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feed_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_feed_ctrl_feed_buffer.sv
`default_nettype none
// ============================================================================
// Module      : feed_buffer
// Description : One-write, one-read register file holding operand cells.
//               Asynchronous read and synchronous write. Contents have no
//               reset, so loaded operands survive a controller reset.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_buffer
   import mac_feed_ctrl_pkg::*;
#(
   parameter int WIDTH  = c_IF_CELL_SIZE,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_ok;
   logic             w_rd_ok;

   // Addresses beyond DEPTH are dropped on write and read back as zero.
   assign w_wr_ok = wr_en && ({1'b0, wr_addr} < c_DEPTH);
   assign w_rd_ok = ({1'b0, rd_addr} < c_DEPTH);

   // Storage update; deliberately no reset on the array.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = w_rd_ok ? r_mem[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/mac_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_feed_ctrl
// Description : Streams operand pairs from two local buffers into a MAC
//               stage for one partial sum of len products. Issues ld_mult
//               one cycle after each buffer read, ld_add one non-stalled
//               cycle later, and par_done alongside the last ld_mult.
//               A downstream stall freezes the whole pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_feed_ctrl
   import mac_feed_ctrl_pkg::*;
#(
   parameter int IF_CELL_SIZE     = c_IF_CELL_SIZE,
   parameter int FILTER_CELL_SIZE = c_FILTER_CELL_SIZE,
   parameter int DEPTH            = 16,
   parameter int ADDR_W           = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        if_wr_en,
   input  logic [ADDR_W-1:0]           if_wr_addr,
   input  logic [IF_CELL_SIZE-1:0]     if_wr_data,
   input  logic                        filt_wr_en,
   input  logic [ADDR_W-1:0]           filt_wr_addr,
   input  logic [FILTER_CELL_SIZE-1:0] filt_wr_data,
   input  logic                        start,
   input  logic [ADDR_W:0]             len,
   input  logic                        stall,
   output logic [IF_CELL_SIZE-1:0]     if_out,
   output logic [FILTER_CELL_SIZE-1:0] filter_out,
   output logic                        ld_mult,
   output logic                        ld_add,
   output logic                        par_done,
   output logic                        busy,
   output logic                        done
);

   localparam logic [ADDR_W:0] c_DEPTH_LEN = (ADDR_W+1)'(DEPTH);

   feed_state_t                 r_state;
   logic [ADDR_W-1:0]           r_k;
   logic [ADDR_W:0]             r_len_q;
   logic                        r_drain;
   logic                        r_mult;
   logic                        r_add;
   logic                        r_pd;
   logic                        r_done;
   logic [IF_CELL_SIZE-1:0]     r_if_out;
   logic [FILTER_CELL_SIZE-1:0] r_filt_out;

   logic                        w_idle;
   logic [ADDR_W:0]             w_len_sat;
   logic                        w_last;
   logic [IF_CELL_SIZE-1:0]     w_if_rd;
   logic [FILTER_CELL_SIZE-1:0] w_filt_rd;

   assign w_idle    = (r_state == IDLE);
   assign w_len_sat = (len > c_DEPTH_LEN) ? c_DEPTH_LEN : len;
   assign w_last    = ({1'b0, r_k} == (r_len_q - (ADDR_W+1)'(1)));

   // Buffers accept writes only while idle, so a running sum sees stable data.
   feed_buffer #(
      .WIDTH  (IF_CELL_SIZE),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_if_buf (
      .clk     (clk),
      .wr_en   (if_wr_en && w_idle),
      .wr_addr (if_wr_addr),
      .wr_data (if_wr_data),
      .rd_addr (r_k),
      .rd_data (w_if_rd)
   );

   feed_buffer #(
      .WIDTH  (FILTER_CELL_SIZE),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_filt_buf (
      .clk     (clk),
      .wr_en   (filt_wr_en && w_idle),
      .wr_addr (filt_wr_addr),
      .wr_data (filt_wr_data),
      .rd_addr (r_k),
      .rd_data (w_filt_rd)
   );

   // Control FSM plus issue/add delay stages; all of it freezes under stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_k        <= '0;
         r_len_q    <= '0;
         r_drain    <= 1'b0;
         r_mult     <= 1'b0;
         r_add      <= 1'b0;
         r_pd       <= 1'b0;
         r_done     <= 1'b0;
         r_if_out   <= '0;
         r_filt_out <= '0;
      end else begin
         r_done <= 1'b0;
         if (!stall) begin
            r_add  <= r_mult;
            r_mult <= 1'b0;
            r_pd   <= 1'b0;
            case (r_state)
               IDLE: begin
                  if (start) begin
                     if (w_len_sat == '0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_state <= RUN;
                        r_len_q <= w_len_sat;
                        r_k     <= '0;
                     end
                  end
               end
               RUN: begin
                  r_if_out   <= w_if_rd;
                  r_filt_out <= w_filt_rd;
                  r_mult     <= 1'b1;
                  r_pd       <= w_last;
                  r_k        <= r_k + 1'b1;
                  if (w_last) begin
                     r_state <= DRAIN;
                     r_drain <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (r_drain) begin
                     r_state <= IDLE;
                     r_drain <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_drain <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Pulses are held in their stages during stall and masked at the port.
   assign if_out     = r_if_out;
   assign filter_out = r_filt_out;
   assign ld_mult    = r_mult & ~stall;
   assign ld_add     = r_add  & ~stall;
   assign par_done   = r_pd   & ~stall;
   assign busy       = ~w_idle;
   assign done       = r_done;

endmodule
`default_nettype wire
